// File: rtl/lfsr_gen.sv
// Parametrised Fibonacci LFSR with a runtime seed load, a counted burst mode
// using a busy/done handshake, and lock-up detection that recovers to SEED.
//
// state    | meaning
// ---------+----------------------------------------------------
// ST_IDLE  | single-step on sh_en; a start is accepted here
// ST_BURST | one shift per cycle until the step counter reaches zero
module lfsr_gen #(
  parameter int unsigned       WIDTH   = 17,
  parameter logic [WIDTH-1:0]  TAPS    = 17'h12000,
  parameter logic [WIDTH-1:0]  SEED    = 17'h082F1,
  parameter bit                XNOR_FB = 1'b1,
  parameter int unsigned       CNT_W   = 17
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sh_en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             start,
  input  logic [CNT_W-1:0] n_steps,
  output logic             busy,
  output logic             done,
  output logic             q_out,
  output logic [WIDTH-1:0] q_state,
  output logic             lockup
);

  typedef enum logic {ST_IDLE, ST_BURST} state_t;

  localparam logic [WIDTH-1:0] LOCK_VAL = XNOR_FB ? {WIDTH{1'b1}} : {WIDTH{1'b0}};

  state_t           state_q, state_d;
  logic [WIDTH-1:0] lfsr_q, lfsr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;
  logic             lock_q, lock_d;
  logic             fb;
  logic             at_lock;
  logic [WIDTH-1:0] step_val;

  assign fb       = (^(lfsr_q & TAPS)) ^ XNOR_FB;
  assign at_lock  = (lfsr_q == LOCK_VAL);
  // A shift attempted from the lock-up value reseeds instead of shifting.
  assign step_val = at_lock ? SEED : {lfsr_q[WIDTH-2:0], fb};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      lfsr_q  <= SEED;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      lock_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      lock_q  <= lock_d;
    end
  end

  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    lock_d  = lock_q | at_lock;
    if (load) begin
      lfsr_d  = load_val;
      lock_d  = 1'b0;
      cnt_d   = '0;
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_BURST: begin
          lfsr_d = step_val;
          cnt_d  = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
        end
        default: begin
          if (start) begin
            if (n_steps == '0) begin
              done_d = 1'b1;
            end else begin
              state_d = ST_BURST;
              cnt_d   = n_steps;
            end
          end else if (sh_en) begin
            lfsr_d = step_val;
          end
        end
      endcase
    end
  end

  assign busy    = (state_q == ST_BURST);
  assign done    = done_q;
  assign q_state = lfsr_q;
  assign q_out   = lfsr_q[WIDTH-1];
  assign lockup  = lock_q;

endmodule

// File: tb/tb_lfsr_gen.sv
// Bench for lfsr_gen: a default 17-bit XNOR instance and an 8-bit XOR instance
// share control inputs and are checked every cycle against a behavioural model.
module tb_lfsr_gen;

  logic        clk = 1'b0;
  logic        rst_n, sh_en, load, start;
  logic [16:0] n_steps;
  logic [16:0] lv_a;
  logic [7:0]  lv_b;

  logic        a_busy, a_done, a_q_out, a_lockup;
  logic [16:0] a_q_state;
  logic        b_busy, b_done, b_q_out, b_lockup;
  logic [7:0]  b_q_state;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  lfsr_gen u_a (
    .clk(clk), .rst_n(rst_n), .sh_en(sh_en), .load(load), .load_val(lv_a),
    .start(start), .n_steps(n_steps), .busy(a_busy), .done(a_done),
    .q_out(a_q_out), .q_state(a_q_state), .lockup(a_lockup)
  );

  lfsr_gen #(.WIDTH(8), .TAPS(8'hB8), .SEED(8'h01), .XNOR_FB(1'b0), .CNT_W(17)) u_b (
    .clk(clk), .rst_n(rst_n), .sh_en(sh_en), .load(load), .load_val(lv_b),
    .start(start), .n_steps(n_steps), .busy(b_busy), .done(b_done),
    .q_out(b_q_out), .q_state(b_q_state), .lockup(b_lockup)
  );

  // Behavioural model: remaining-step count instead of an FSM, arithmetic feedback.
  typedef struct {
    logic [31:0] st;
    bit          busy;
    int          rem;
    bit          done;
    bit          lock;
  } mdl_t;

  mdl_t ma, mb;

  function automatic logic [31:0] advance(input logic [31:0] st, input int w,
                                          input logic [31:0] taps, input bit xn,
                                          input logic [31:0] seed);
    logic [31:0] mask;
    logic [31:0] lv;
    int          par;
    mask = (32'h1 << w) - 32'h1;
    lv   = xn ? mask : 32'h0;
    if (st == lv) return seed;
    par = ($countones(st & taps) % 2) ^ int'(xn);
    return ((st * 2) & mask) + 32'(par);
  endfunction

  task automatic model_step(inout mdl_t m, input int w, input logic [31:0] taps,
                            input bit xn, input logic [31:0] seed, input logic [31:0] lval);
    logic [31:0] mask;
    logic [31:0] lv;
    mask = (32'h1 << w) - 32'h1;
    lv   = xn ? mask : 32'h0;
    if (!rst_n) begin
      m.st = seed; m.busy = 0; m.rem = 0; m.done = 0; m.lock = 0;
      return;
    end
    m.lock = m.lock || (m.st == lv);
    m.done = 0;
    if (load) begin
      m.st = lval & mask; m.lock = 0; m.busy = 0; m.rem = 0;
    end else if (m.busy) begin
      m.st  = advance(m.st, w, taps, xn, seed);
      m.rem = m.rem - 1;
      if (m.rem == 0) begin
        m.busy = 0; m.done = 1;
      end
    end else if (start) begin
      if (n_steps == 17'd0) m.done = 1;
      else begin
        m.busy = 1; m.rem = int'(n_steps);
      end
    end else if (sh_en) begin
      m.st = advance(m.st, w, taps, xn, seed);
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("a_state", 32'(a_q_state), ma.st);
    chk("a_q_out", 32'(a_q_out), 32'(ma.st[16]));
    chk("a_busy", 32'(a_busy), 32'(ma.busy));
    chk("a_done", 32'(a_done), 32'(ma.done));
    chk("a_lockup", 32'(a_lockup), 32'(ma.lock));
    chk("b_state", 32'(b_q_state), mb.st);
    chk("b_q_out", 32'(b_q_out), 32'(mb.st[7]));
    chk("b_busy", 32'(b_busy), 32'(mb.busy));
    chk("b_done", 32'(b_done), 32'(mb.done));
    chk("b_lockup", 32'(b_lockup), 32'(mb.lock));
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step(ma, 17, 32'h12000, 1'b1, 32'h082F1, 32'(lv_a));
    model_step(mb, 8, 32'hB8, 1'b0, 32'h01, 32'(lv_b));
    #1;
    check_all();
  endtask

  task automatic idle_inputs();
    rst_n = 1'b1; sh_en = 1'b0; load = 1'b0; start = 1'b0; n_steps = '0;
  endtask

  initial begin
    ma = '{st: 32'h0, busy: 0, rem: 0, done: 0, lock: 0};
    mb = ma;
    idle_inputs();
    lv_a = '0; lv_b = '0;

    // reset, then two single steps
    rst_n = 1'b0; cyc();
    chk("rst_state", 32'(a_q_state), 32'h082F1);
    chk("rst_q_out", 32'(a_q_out), 32'h0);
    rst_n = 1'b1; sh_en = 1'b1;
    cyc(); chk("step1_state", 32'(a_q_state), 32'h105E3); chk("step1_q_out", 32'(a_q_out), 32'h1);
    cyc(); chk("step2_state", 32'(a_q_state), 32'h00BC6); chk("step2_q_out", 32'(a_q_out), 32'h0);
    sh_en = 1'b0; cyc();

    // full 255-step burst on the 8-bit instance starting from its seed
    rst_n = 1'b0; cyc(); rst_n = 1'b1;
    start = 1'b1; n_steps = 17'd255; cyc();
    start = 1'b0; n_steps = '0;
    begin
      int busy_cnt;
      busy_cnt = 0;
      for (int i = 0; i < 255; i++) begin
        if (b_busy) busy_cnt++;
        cyc();
        if (i < 254) chk("b_no_seed_mid", 32'(b_q_state == 8'h01), 32'h0);
      end
      chk("b_busy_cycles", 32'(busy_cnt), 32'd255);
      chk("b_period_state", 32'(b_q_state), 32'h01);
      chk("b_done_pulse", 32'(b_done), 32'h1);
    end
    cyc(); chk("b_done_once", 32'(b_done), 32'h0);

    // lock-up load and recovery
    load = 1'b1; lv_a = 17'h1FFFF; lv_b = 8'h00; cyc();
    load = 1'b0; chk("lock_not_yet", 32'(a_lockup), 32'h0);
    sh_en = 1'b1; cyc();
    chk("lock_recover", 32'(a_q_state), 32'h082F1); chk("lock_set", 32'(a_lockup), 32'h1);
    repeat (3) cyc();
    chk("lock_sticky", 32'(a_lockup), 32'h1);
    sh_en = 1'b0; load = 1'b1; lv_a = 17'h00123; lv_b = 8'h5A; cyc();
    load = 1'b0; chk("lock_cleared", 32'(a_lockup), 32'h0);

    // burst aborted by load at burst cycle 4
    start = 1'b1; n_steps = 17'd10; cyc();
    start = 1'b0; repeat (3) cyc();
    load = 1'b1; lv_a = 17'h00001; lv_b = 8'h01; cyc();
    load = 1'b0;
    chk("abort_busy", 32'(a_busy), 32'h0); chk("abort_state", 32'(a_q_state), 32'h1);
    cyc(); chk("abort_no_done", 32'(a_done), 32'h0);

    // zero-length burst, then start/sh_en while busy
    start = 1'b1; n_steps = '0; cyc();
    start = 1'b0;
    chk("zero_done", 32'(a_done), 32'h1); chk("zero_busy", 32'(a_busy), 32'h0);
    chk("zero_state", 32'(a_q_state), 32'h1);
    start = 1'b1; n_steps = 17'd5; cyc();
    n_steps = 17'd9; sh_en = 1'b1;
    repeat (5) cyc();
    chk("busy_ign_done", 32'(a_done), 32'h1);
    idle_inputs(); cyc();

    // reset mid-burst
    start = 1'b1; n_steps = 17'd20; cyc();
    start = 1'b0; repeat (6) cyc();
    rst_n = 1'b0; cyc(); rst_n = 1'b1;
    chk("mid_rst_state", 32'(a_q_state), 32'h082F1); chk("mid_rst_busy", 32'(a_busy), 32'h0);
    chk("mid_rst_b_state", 32'(b_q_state), 32'h01);
    cyc(); chk("mid_rst_no_done", 32'(a_done), 32'h0);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      rst_n   = ($urandom_range(0, 199) != 0);
      load    = ($urandom_range(0, 29) == 0);
      start   = ($urandom_range(0, 9) == 0);
      sh_en   = $urandom_range(0, 1) == 1;
      n_steps = 17'($urandom_range(0, 20));
      lv_a    = ($urandom_range(0, 3) == 0) ? 17'h1FFFF : 17'($urandom);
      lv_b    = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
      cyc();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
